// File: rtl/hdlc_line_monitor_if.sv
// ---------------------------------------------------------------------------
// hdlc_line_monitor_if
// Bundles the per-channel serial taps, counter read port and status outputs
// of the HDLC line monitor.
//   bit_en       per-channel bit strobe (rx_bit sampled only when set)
//   rx_bit       raw serial bit per channel
//   clr          synchronous clear of all event counters
//   rd_sel       channel whose counters appear on the rd_* outputs
//   flag_det     1-cycle pulse, flag 01111110 completed
//   frame_end    1-cycle pulse, closing flag of a frame
//   abort_det    1-cycle pulse, abort inside a frame
//   short_err    1-cycle pulse, closed frame shorter than the minimum
//   in_frame     level, channel inside a frame
//   idle         level, ones-run reached the idle length
//   rd_*_cnt     registered counters of channel rd_sel
// master: the side that drives the line taps; slave: the monitor itself.
// ---------------------------------------------------------------------------
interface hdlc_line_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int RS_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] bit_en;
    logic [NUM_CH-1:0] rx_bit;
    logic              clr;
    logic [RS_W-1:0]   rd_sel;

    logic [NUM_CH-1:0] flag_det;
    logic [NUM_CH-1:0] frame_end;
    logic [NUM_CH-1:0] abort_det;
    logic [NUM_CH-1:0] short_err;
    logic [NUM_CH-1:0] in_frame;
    logic [NUM_CH-1:0] idle;
    logic [CNT_W-1:0]  rd_frame_cnt;
    logic [CNT_W-1:0]  rd_abort_cnt;
    logic [CNT_W-1:0]  rd_err_cnt;

    modport master (
        output bit_en, rx_bit, clr, rd_sel,
        input  flag_det, frame_end, abort_det, short_err, in_frame, idle,
        input  rd_frame_cnt, rd_abort_cnt, rd_err_cnt
    );

    modport slave (
        input  bit_en, rx_bit, clr, rd_sel,
        output flag_det, frame_end, abort_det, short_err, in_frame, idle,
        output rd_frame_cnt, rd_abort_cnt, rd_err_cnt
    );
endinterface

// File: rtl/hdlc_line_monitor.sv
// ---------------------------------------------------------------------------
// hdlc_line_monitor
// Multi-channel HDLC receive-line monitor. Taps the raw bitstream of each
// channel, detects flags, aborts and idle, tracks frame state and length,
// and keeps saturating per-channel frame/abort/short-frame counters that are
// readable through a registered channel-select port.
//   clk    rising-edge clock for all logic
//   rst_n  asynchronous active-low reset
//   mon    hdlc_line_monitor_if.slave (taps, clear, read select, status)
// ---------------------------------------------------------------------------
module hdlc_line_monitor #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int IDLE_LEN       = 15,
    parameter int MIN_FRAME_BITS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hdlc_line_monitor_if.slave  mon
);
    localparam int ONES_W = $clog2(IDLE_LEN + 1);
    // Length counter must hold MIN_FRAME_BITS + 8 (the closing flag's bits).
    localparam int LEN_W  = $clog2(MIN_FRAME_BITS + 9);

    localparam logic [ONES_W-1:0] ONES_SAT   = ONES_W'(IDLE_LEN);
    localparam logic [ONES_W-1:0] ONES_ABORT = ONES_W'(7);
    localparam logic [LEN_W-1:0]  LEN_MAX    = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0]  LEN_OPEN   = LEN_W'(8);
    localparam logic [LEN_W-1:0]  LEN_MIN_OK = LEN_W'(MIN_FRAME_BITS + 8);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_FLAG  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [NUM_CH-1:0] flag_det_s;
    logic [NUM_CH-1:0] frame_end_s;
    logic [NUM_CH-1:0] abort_det_s;
    logic [NUM_CH-1:0] short_err_s;
    logic [NUM_CH-1:0] in_frame_s;
    logic [NUM_CH-1:0] idle_s;
    logic [CNT_W-1:0]  frame_cnt_s [NUM_CH];
    logic [CNT_W-1:0]  abort_cnt_s [NUM_CH];
    logic [CNT_W-1:0]  err_cnt_s   [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t            st_r, st_nx;
        // Last 7 sampled bits; with the incoming bit they form the 8-bit
        // shift value. Reset to all ones so no flag can form early.
        logic [6:0]        hist_r, hist_nx;
        logic [7:0]        shift_s;
        logic [ONES_W-1:0] ones_r, ones_nx;
        logic [LEN_W-1:0]  len_r, len_nx, len_inc_s;
        logic              flag_s, seven_s, idle_nx;
        logic              fend_s, abort_s, short_s;
        logic              flag_det_r, frame_end_r, abort_det_r, short_err_r;
        logic              in_frame_r, idle_r;
        logic [CNT_W-1:0]  frame_cnt_r, abort_cnt_r, err_cnt_r;

        // Bit-level datapath: shift value, ones-run and bits-since-flag
        always_comb begin
            shift_s   = {hist_r, mon.rx_bit[c]};
            hist_nx   = hist_r;
            ones_nx   = ones_r;
            len_nx    = len_r;
            len_inc_s = (len_r == LEN_MAX) ? len_r : len_r + LEN_W'(1);
            flag_s    = 1'b0;
            seven_s   = 1'b0;
            idle_nx   = idle_r;
            if (mon.bit_en[c]) begin
                hist_nx = shift_s[6:0];
                if (mon.rx_bit[c]) begin
                    if (ones_r == ONES_SAT) begin
                        ones_nx = ones_r;
                    end else begin
                        ones_nx = ones_r + ONES_W'(1);
                    end
                end else begin
                    ones_nx = '0;
                end
                flag_s  = (shift_s == 8'h7E);
                // Only reachable on the 6->7 step, so this fires once per run.
                seven_s = (ones_nx == ONES_ABORT);
                idle_nx = (ones_nx >= ONES_SAT);
                if (flag_s) begin
                    len_nx = '0;
                end else begin
                    len_nx = len_inc_s;
                end
            end else begin
                hist_nx = hist_r;
            end
        end

        // Frame FSM next-state and event pulses
        always_comb begin
            st_nx   = st_r;
            fend_s  = 1'b0;
            abort_s = 1'b0;
            short_s = 1'b0;
            if (mon.bit_en[c]) begin
                if (idle_nx) begin
                    st_nx = ST_HUNT;
                end else begin
                    case (st_r)
                        ST_HUNT: begin
                            if (flag_s) begin
                                st_nx = ST_FLAG;
                            end else begin
                                st_nx = ST_HUNT;
                            end
                        end
                        ST_FLAG: begin
                            if (flag_s) begin
                                st_nx = ST_FLAG;
                            end else if (seven_s) begin
                                st_nx = ST_HUNT;
                            end else if (len_inc_s == LEN_OPEN) begin
                                st_nx = ST_FRAME;
                            end else begin
                                st_nx = ST_FLAG;
                            end
                        end
                        ST_FRAME: begin
                            if (flag_s) begin
                                st_nx   = ST_FLAG;
                                fend_s  = 1'b1;
                                // len_inc_s counts data plus the 8 flag bits.
                                short_s = (len_inc_s < LEN_MIN_OK);
                            end else if (seven_s) begin
                                st_nx   = ST_HUNT;
                                abort_s = 1'b1;
                            end else begin
                                st_nx = ST_FRAME;
                            end
                        end
                        default: begin
                            st_nx = ST_HUNT;
                        end
                    endcase
                end
            end else begin
                st_nx = st_r;
            end
        end

        // FSM state register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_r <= ST_HUNT;
            end else begin
                st_r <= st_nx;
            end
        end

        // Datapath registers and registered status outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist_r      <= 7'h7F;
                ones_r      <= '0;
                len_r       <= '0;
                flag_det_r  <= 1'b0;
                frame_end_r <= 1'b0;
                abort_det_r <= 1'b0;
                short_err_r <= 1'b0;
                in_frame_r  <= 1'b0;
                idle_r      <= 1'b0;
            end else begin
                hist_r      <= hist_nx;
                ones_r      <= ones_nx;
                len_r       <= len_nx;
                flag_det_r  <= flag_s;
                frame_end_r <= fend_s;
                abort_det_r <= abort_s;
                short_err_r <= short_s;
                in_frame_r  <= (st_nx == ST_FRAME);
                idle_r      <= idle_nx;
            end
        end

        // Saturating event counters; clear overrides a same-cycle increment
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                frame_cnt_r <= '0;
                abort_cnt_r <= '0;
                err_cnt_r   <= '0;
            end else if (mon.clr) begin
                frame_cnt_r <= '0;
                abort_cnt_r <= '0;
                err_cnt_r   <= '0;
            end else begin
                frame_cnt_r <= fend_s  ? sat_inc(frame_cnt_r) : frame_cnt_r;
                abort_cnt_r <= abort_s ? sat_inc(abort_cnt_r) : abort_cnt_r;
                err_cnt_r   <= short_s ? sat_inc(err_cnt_r)   : err_cnt_r;
            end
        end

        assign flag_det_s[c]  = flag_det_r;
        assign frame_end_s[c] = frame_end_r;
        assign abort_det_s[c] = abort_det_r;
        assign short_err_s[c] = short_err_r;
        assign in_frame_s[c]  = in_frame_r;
        assign idle_s[c]      = idle_r;
        assign frame_cnt_s[c] = frame_cnt_r;
        assign abort_cnt_s[c] = abort_cnt_r;
        assign err_cnt_s[c]   = err_cnt_r;
    end

    logic [CNT_W-1:0] rd_frame_r, rd_abort_r, rd_err_r;

    // Registered counter read port; out-of-range selects read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_frame_r <= '0;
            rd_abort_r <= '0;
            rd_err_r   <= '0;
        end else if (int'(mon.rd_sel) < NUM_CH) begin
            rd_frame_r <= frame_cnt_s[mon.rd_sel];
            rd_abort_r <= abort_cnt_s[mon.rd_sel];
            rd_err_r   <= err_cnt_s[mon.rd_sel];
        end else begin
            rd_frame_r <= '0;
            rd_abort_r <= '0;
            rd_err_r   <= '0;
        end
    end

    assign mon.flag_det     = flag_det_s;
    assign mon.frame_end    = frame_end_s;
    assign mon.abort_det    = abort_det_s;
    assign mon.short_err    = short_err_s;
    assign mon.in_frame     = in_frame_s;
    assign mon.idle         = idle_s;
    assign mon.rd_frame_cnt = rd_frame_r;
    assign mon.rd_abort_cnt = rd_abort_r;
    assign mon.rd_err_cnt   = rd_err_r;
endmodule

// File: doc/hdlc_line_monitor.md
# hdlc_line_monitor

Synthesizable, parametrised multi-channel HDLC line monitor for the receive path. It turns the flag, abort and idle checks from the bench into per-channel RTL: shift-register detection, a per-channel frame state machine, short-frame checking and saturating event counters. Counters are readable through a registered select port. It sits beside the HDLC receiver on the serial line(s), taps the raw bitstream and produces status pulses and statistics without altering the data path.

## Interface
- NUM_CH, 4: number of independent serial channels (≥1)
- CNT_W, 16: width of each saturating event counter
- IDLE_LEN, 15: consecutive 1s that declare line idle (≥8)
- MIN_FRAME_BITS, 32: minimum raw bits between flags for a valid frame
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- BitEn  in  NUM_CH  per-channel bit strobe; RxBit[c] sampled only when BitEn[c]=1
- RxBit  in  NUM_CH  raw serial bit per channel
- Clr  in  1  synchronous clear of all counters
- RdSel  in  max(1,$clog2(NUM_CH))  channel select for counter read
- FlagDet  out  NUM_CH  1-cycle pulse, flag 01111110 completed
- FrameEnd  out  NUM_CH  1-cycle pulse, closing flag of a frame
- AbortDet  out  NUM_CH  1-cycle pulse, abort during frame
- ShortErr  out  NUM_CH  1-cycle pulse, frame shorter than MIN_FRAME_BITS
- InFrame  out  NUM_CH  level, channel in FRAME state
- Idle  out  NUM_CH  level, ones-run ≥ IDLE_LEN
- RdFrameCnt, RdAbortCnt, RdErrCnt  out  CNT_W each  counters of channel RdSel, registered

## Operation
- Per channel: 8-bit shift register (newest bit LSB), ones-run counter saturating at IDLE_LEN, bits-since-flag counter, 2-bit state, three CNT_W counters.
- Rst low: shift reg = 8'hFF (prevents false flag on first 7 bits), ones-run 0, state HUNT, counters 0, all outputs 0.
- BitEn[c]=0: channel c holds all state; no pulses.
- Flag: new shift value == 8'h7E. Abort: ones-run reaches 7. Idle: ones-run ≥ IDLE_LEN; any 0 clears ones-run.
- States:
  - HUNT: flag → FLAG.
  - FLAG: flag → FLAG (reset bit count). 7 ones → HUNT, no AbortDet. Bit count reaches 8 with no flag → FRAME (InFrame rises).
  - FRAME: flag → FLAG with FrameEnd; FrameCnt++. Abort → HUNT with AbortDet; AbortCnt++.
  - Idle in any state → HUNT.
- Frame length L = raw bits sampled after the opening flag's final 0, up to and including the closing flag's final 0, minus 8. Stuffed zeros are counted.
  - L < MIN_FRAME_BITS → ShortErr with FrameEnd; ErrCnt++.
  - Length counter saturates and never wraps.
- Counters saturate at 2^CNT_W−1. Clr and an increment in the same cycle: Clr wins, result 0.
- A flag pulses FlagDet in every state, including HUNT.

## Timing
- Detection latency 1: pulses and levels are registered at the same edge that samples the completing bit.
- FlagDet and FrameEnd assert in the same cycle for a closing flag.
- Shared-zero flags (0111111011111 10…): second FlagDet 7 sampled bits after the first.
- InFrame rises at the edge sampling the 8th bit after the flag. It falls at the edge of the closing flag, abort or idle.
- Idle rises at the edge sampling the IDLE_LEN-th consecutive 1. It falls at the edge sampling the next 0.
- Rd* outputs are registered from RdSel and counters: 1-cycle latency, reset 0.
- Rst asserted mid-frame: immediate return to reset values. No FrameEnd or AbortDet is generated.

## Test plan
- Reset, ch0 BitEn=1, send 1111110 → no FlagDet. Then 01111110 → FlagDet[0] high exactly 1 cycle at the 8th bit; InFrame[0]=0.
- Flag, 40 bits of 0101…, flag → InFrame rises 8 bits after the first flag. FrameEnd=1, ShortErr=0; RdSel=0 → RdFrameCnt=1 one cycle later. Repeat with 16 data bits → ShortErr pulse, RdErrCnt=1.
- Flag, 20 data bits, 0 then 1111111 → AbortDet at 7th 1, InFrame 0, RdAbortCnt=1. Flag then immediately 1111111 → no AbortDet, state HUNT.
- 15 consecutive 1s → Idle rises at the 15th; a 0 clears it the next cycle. A subsequent frame without a new flag is not recognised.
- NUM_CH=4: ch2 frames with BitEn[2] toggling every other cycle, while ch0 idles → ch2 counts correctly, ch0 unaffected. Back-to-back shared-zero flags → two FlagDet 7 bits apart.
- CNT_W=2: 5 frames → RdFrameCnt=3 (saturated). Clr coinciding with FrameEnd → 0. Rst low mid-frame → all outputs 0 asynchronously.
